mem_stage: RTL

Memory-access pipeline stage directly downstream of the execute stage and upstream of write-back. Accepts the execute bundle, samples synchronous data-SRAM read data one cycle after the execute-stage request, and extracts and extends load results. Forwards a bypass bundle to decode and an exception flag back to execute, which uses it to cancel younger stores. Holds a one-entry read-data buffer so load data survives write-back back-pressure.

---
 rtl/mycpu_pkg.sv | 57 +++++
 rtl/ms_load_align.sv | 36 +++
 rtl/mem_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared widths, field layouts and load-op bit indices for the memory stage
package mycpu_pkg;

    localparam int EXC_W    = 84;
    localparam int RF_ZIP_W = 40;

    // ld_op = {b, bu, h, hu, w}
    localparam int LD_B  = 4;
    localparam int LD_BU = 3;
    localparam int LD_H  = 2;
    localparam int LD_HU = 1;
    localparam int LD_W  = 0;

    localparam int ES2MS_W = 78 + EXC_W;
    localparam int MS2WS_W = 72 + EXC_W;

    localparam int ES_ALE_BIT   = 0;
    localparam int ES_EXC_LSB   = 1;
    localparam int ES_ALU_LSB   = ES_EXC_LSB + EXC_W;
    localparam int ES_WADDR_LSB = ES_ALU_LSB + 32;
    localparam int ES_RFWE_BIT  = ES_WADDR_LSB + 5;
    localparam int ES_CSRRE_BIT = ES_RFWE_BIT + 1;
    localparam int ES_RFM_BIT   = ES_CSRRE_BIT + 1;
    localparam int ES_PC_LSB    = ES_RFM_BIT + 1;
    localparam int ES_LDOP_LSB  = ES_PC_LSB + 32;

    localparam int WS_ALE_BIT   = 0;
    localparam int WS_EXC_LSB   = 1;
    localparam int WS_FINAL_LSB = WS_EXC_LSB + EXC_W;
    localparam int WS_WADDR_LSB = WS_FINAL_LSB + 32;
    localparam int WS_RFWE_BIT  = WS_WADDR_LSB + 5;
    localparam int WS_CSRRE_BIT = WS_RFWE_BIT + 1;
    localparam int WS_PC_LSB    = WS_CSRRE_BIT + 1;

    typedef struct packed {
        logic [4:0]       ld_op;
        logic [31:0]      pc;
        logic             res_from_mem;
        logic             csr_re;
        logic             rf_we;
        logic [4:0]       rf_waddr;
        logic [31:0]      alu_result;
        logic [EXC_W-1:0] exc;
        logic             ale;
    } es2ms_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic             csr_re;
        logic             rf_we;
        logic [4:0]       rf_waddr;
        logic [31:0]      final_result;
        logic [EXC_W-1:0] exc;
        logic             ale;
    } ms2ws_t;

endpackage

// File: rtl/ms_load_align.sv
// rtl/ms_load_align.sv - selects and extends the loaded byte/halfword/word from the read word
module ms_load_align
    import mycpu_pkg::*;
(
    input  logic [4:0]  i_ld_op,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_word,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_result = i_ld_op[LD_W] ? i_word : 32'h0;
        if (i_ld_op[LD_B])
            o_result = {{24{w_byte[7]}}, w_byte};
        else if (i_ld_op[LD_BU])
            o_result = {24'h0, w_byte};
        else if (i_ld_op[LD_H])
            o_result = {{16{w_half[15]}}, w_half};
        else if (i_ld_op[LD_HU])
            o_result = {16'h0, w_half};
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with one-entry load-data buffer; MS_LOAD_FWD_EN makes loads forwardable from MEM
module mem_stage
    import mycpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                es2ms_valid,
    input  logic [ES2MS_W-1:0]  es2ms_bus,
    output logic                ms_allowin,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ws_allowin,
    output logic                ms2ws_valid,
    output logic [MS2WS_W-1:0]  ms2ws_bus,
    output logic [RF_ZIP_W-1:0] ms_rf_zip,
    output logic                ms_ex,
    output logic [31:0]         ms_pc,
    input  logic                wb_ex
);

    logic        r_valid;
    logic        r_first;
    es2ms_t      r_es;
    logic [31:0] r_ld_buf;

    logic        w_ready_go;
    logic        w_load_en;
    logic        w_ld_nofwd;
    logic [31:0] w_mem_word;
    logic [31:0] w_aligned;
    logic [31:0] w_final;

    assign w_ready_go = 1'b1;
    assign ms_allowin = ~r_valid | (w_ready_go & ws_allowin);
    assign w_load_en  = es2ms_valid & ms_allowin;

    always_ff @(posedge clk) begin
        if (reset)
            r_valid <= 1'b0;
        else if (wb_ex)
            r_valid <= 1'b0;
        else if (ms_allowin)
            r_valid <= es2ms_valid;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_es <= '0;
        else if (w_load_en)
            r_es <= es2ms_t'(es2ms_bus);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_first <= 1'b0;
        else
            r_first <= w_load_en & ~wb_ex;
    end

    // SRAM data is only valid the cycle after the request; keep it for stalled cycles
    always_ff @(posedge clk) begin
        if (reset)
            r_ld_buf <= 32'h0;
        else if (r_valid & r_first)
            r_ld_buf <= data_sram_rdata;
    end

    assign w_mem_word = r_first ? data_sram_rdata : r_ld_buf;

    ms_load_align u_load_align (
        .i_ld_op  (r_es.ld_op),
        .i_addr   (r_es.alu_result[1:0]),
        .i_word   (w_mem_word),
        .o_result (w_aligned)
    );

    assign w_final = r_es.res_from_mem ? w_aligned : r_es.alu_result;

`ifdef MS_LOAD_FWD_EN
    assign w_ld_nofwd = 1'b0;
`else
    assign w_ld_nofwd = r_es.res_from_mem;
`endif

    assign ms2ws_valid = r_valid & w_ready_go;
    assign ms2ws_bus   = {r_es.pc, r_es.csr_re, r_es.rf_we, r_es.rf_waddr,
                          w_final, r_es.exc, r_es.ale};
    assign ms_rf_zip   = {r_es.csr_re & r_valid, w_ld_nofwd & r_valid, r_es.rf_we & r_valid,
                          r_es.rf_waddr, w_final};
    assign ms_ex       = r_valid & ((|r_es.exc) | r_es.ale);
    assign ms_pc       = r_es.pc;

endmodule
